// File: rtl/tmr_sequencer_pkg.sv
// Shared timer package: watchdog width/limit defaults and sequencer state encoding.
package tmr_sequencer_pkg;

  localparam int unsigned WDOG_W = 21;
  localparam logic [WDOG_W-1:0] WDOG_MAX_DFLT = 21'h1FFFFF;
  localparam int unsigned STEP_W_DFLT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tmr_sequencer_wdog.sv
// Saturating WAIT-cycle watchdog; expired flags the enabled cycle whose increment reaches MAX.
module tmr_wdog
  import tmr_sequencer_pkg::*;
#(
  parameter logic [WDOG_W-1:0] MAX = WDOG_MAX_DFLT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Asserted combinationally so the FSM can enter FAULT on the same edge the count hits MAX.
  assign expired = enable && (cnt == (MAX - WDOG_W'(1)));

endmodule

// File: rtl/tmr_sequencer.sv
// Step sequencer driving an external timer: N intervals per GO, with watchdog and abort.
module tmr_sequencer
  import tmr_sequencer_pkg::*;
#(
  parameter logic [WDOG_W-1:0] WDOG_MAX = WDOG_MAX_DFLT,
  parameter int unsigned       STEP_W   = STEP_W_DFLT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              GO,
  input  logic [STEP_W-1:0] N_STEPS,
  input  logic              ABORT,
  input  logic              TMR_PULSE,
  output logic              START_TMR,
  output logic              BUSY,
  output logic [STEP_W-1:0] STEP,
  output logic              STEP_TICK,
  output logic              DONE,
  output logic              TIMEOUT
);

  seq_state_t        state;
  logic [STEP_W-1:0] n_lat;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_nxt;
  logic              start_q;
  logic              tick_q;
  logic              done_q;
  logic              timeout_q;
  logic              wdog_clear;
  logic              wdog_en;
  logic              wdog_exp;

  assign step_nxt   = step_q + 1'b1;
  assign wdog_clear = (state != ST_WAIT);
  assign wdog_en    = (state == ST_WAIT) && !TMR_PULSE;

  tmr_wdog #(
    .MAX(WDOG_MAX)
  ) u_wdog (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (wdog_clear),
    .enable (wdog_en),
    .expired(wdog_exp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      n_lat     <= '0;
      step_q    <= '0;
      start_q   <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      if (ABORT) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (GO) begin
              if (N_STEPS != '0) begin
                n_lat     <= N_STEPS;
                step_q    <= '0;
                timeout_q <= 1'b0;
                state     <= ST_ARM;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ST_ARM: begin
            start_q <= 1'b1;
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            // A timer pulse wins over a simultaneous watchdog expiry.
            if (TMR_PULSE) begin
              step_q <= step_nxt;
              tick_q <= 1'b1;
              if (step_nxt == n_lat) begin
                done_q <= 1'b1;
                state  <= ST_IDLE;
              end else begin
                state <= ST_ARM;
              end
            end else if (wdog_exp) begin
              timeout_q <= 1'b1;
              state     <= ST_FAULT;
            end
          end
          ST_FAULT: state <= ST_FAULT;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign START_TMR = start_q;
  assign BUSY      = (state != ST_IDLE);
  assign STEP      = step_q;
  assign STEP_TICK = tick_q;
  assign DONE      = done_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_tmr_sequencer.sv
// Directed bench for tmr_sequencer: per-cycle vector table plus multi-cycle scenarios.
module tb_tmr_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       GO;
  logic [3:0] N_STEPS;
  logic       ABORT;
  logic       TMR_PULSE;
  logic       START_TMR;
  logic       BUSY;
  logic [3:0] STEP;
  logic       STEP_TICK;
  logic       DONE;
  logic       TIMEOUT;

  int total = 0;
  int bad   = 0;

  tmr_sequencer #(
    .WDOG_MAX(21'd16),
    .STEP_W  (4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .GO       (GO),
    .N_STEPS  (N_STEPS),
    .ABORT    (ABORT),
    .TMR_PULSE(TMR_PULSE),
    .START_TMR(START_TMR),
    .BUSY     (BUSY),
    .STEP     (STEP),
    .STEP_TICK(STEP_TICK),
    .DONE     (DONE),
    .TIMEOUT  (TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic       go;
    logic [3:0] n;
    logic       abort;
    logic       pulse;
    logic [8:0] exp; // {START_TMR, BUSY, STEP[3:0], STEP_TICK, DONE, TIMEOUT}
  } vec_t;

  function automatic vec_t v(input logic go, input logic [3:0] n, input logic ab,
                             input logic pu, input logic st, input logic bz,
                             input logic [3:0] sp, input logic tk, input logic dn,
                             input logic to);
    vec_t r;
    r.go    = go;
    r.n     = n;
    r.abort = ab;
    r.pulse = pu;
    r.exp   = {st, bz, sp, tk, dn, to};
    return r;
  endfunction

  function automatic logic [8:0] outs();
    return {START_TMR, BUSY, STEP, STEP_TICK, DONE, TIMEOUT};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    GO = 1'b0; N_STEPS = 4'd0; ABORT = 1'b0; TMR_PULSE = 1'b0;
  endtask

  vec_t vt [19];

  initial begin
    int starts;
    int ticks;
    int dly;
    int lat_bad;
    bit prev_tick;
    bit got_done;

    vt[0]  = v(0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    vt[1]  = v(1, 0,  0, 0,  0, 0, 0, 0, 1, 0);
    vt[2]  = v(0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
    vt[3]  = v(0, 0,  0, 1,  0, 0, 0, 0, 0, 0);
    vt[4]  = v(1, 1,  0, 0,  0, 1, 0, 0, 0, 0);
    vt[5]  = v(0, 0,  0, 0,  1, 1, 0, 0, 0, 0);
    vt[6]  = v(0, 0,  0, 0,  0, 1, 0, 0, 0, 0);
    vt[7]  = v(0, 0,  0, 1,  0, 0, 1, 1, 1, 0);
    vt[8]  = v(0, 0,  0, 0,  0, 0, 1, 0, 0, 0);
    vt[9]  = v(1, 2,  1, 0,  0, 0, 1, 0, 0, 0);
    vt[10] = v(1, 2,  0, 0,  0, 1, 0, 0, 0, 0);
    vt[11] = v(0, 0,  1, 0,  0, 0, 0, 0, 0, 0);
    vt[12] = v(1, 2,  0, 0,  0, 1, 0, 0, 0, 0);
    vt[13] = v(0, 0,  0, 0,  1, 1, 0, 0, 0, 0);
    vt[14] = v(0, 0,  0, 1,  0, 1, 1, 1, 0, 0);
    vt[15] = v(0, 0,  0, 1,  1, 1, 1, 0, 0, 0);
    vt[16] = v(0, 0,  0, 1,  0, 0, 2, 1, 1, 0);
    vt[17] = v(1, 15, 0, 0,  0, 1, 0, 0, 0, 0);
    vt[18] = v(0, 0,  1, 1,  0, 0, 0, 0, 0, 0);

    idle_inputs();
    RST_N = 1'b0;
    #3;
    chk("reset_outputs", 32'(outs()), 32'd0);
    tick();
    tick();
    chk("reset_hold", 32'(outs()), 32'd0);
    RST_N = 1'b1;

    // Per-cycle vector table
    for (int i = 0; i < 19; i++) begin
      GO = vt[i].go; N_STEPS = vt[i].n; ABORT = vt[i].abort; TMR_PULSE = vt[i].pulse;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end
    idle_inputs();
    tick();

    // Three-step run, timer replying 10 cycles after each start
    GO = 1'b1; N_STEPS = 4'd3;
    tick();
    idle_inputs();
    starts = 0; ticks = 0; dly = 0; lat_bad = 0; prev_tick = 1'b0; got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      tick();
      TMR_PULSE = 1'b0;
      if (START_TMR) begin
        starts++;
        dly = 10;
      end
      if (prev_tick && !START_TMR) lat_bad++;
      if (STEP_TICK) ticks++;
      if (DONE) begin
        got_done = 1'b1;
        chk("run3_step", 32'(STEP), 32'd3);
        chk("run3_busy_at_done", 32'(BUSY), 32'd0);
        chk("run3_timeout", 32'(TIMEOUT), 32'd0);
      end
      prev_tick = STEP_TICK && !DONE;
      if (dly > 0) begin
        dly--;
        if (dly == 0) TMR_PULSE = 1'b1;
      end
    end
    TMR_PULSE = 1'b0;
    chk("run3_done_seen", 32'(got_done), 32'd1);
    chk("run3_starts", 32'(starts), 32'd3);
    chk("run3_ticks", 32'(ticks), 32'd3);
    chk("run3_tick_to_start", 32'(lat_bad), 32'd0);
    tick();
    chk("run3_done_one_cycle", 32'(DONE), 32'd0);

    // Watchdog expiry: 16 WAIT cycles without a pulse
    GO = 1'b1; N_STEPS = 4'd2;
    tick();
    idle_inputs();
    tick();
    chk("wd_start", 32'(START_TMR), 32'd1);
    for (int k = 0; k < 15; k++) tick();
    chk("wd_not_yet", 32'({TIMEOUT, BUSY}), 32'b01);
    tick();
    chk("wd_expired", 32'({TIMEOUT, BUSY}), 32'b11);
    TMR_PULSE = 1'b1;
    tick();
    TMR_PULSE = 1'b0;
    chk("fault_ignores_pulse", 32'({STEP_TICK, STEP}), 32'd0);
    tick();
    tick();
    chk("fault_holds", 32'({TIMEOUT, BUSY}), 32'b11);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("fault_abort", 32'({TIMEOUT, BUSY}), 32'b10);
    GO = 1'b1; N_STEPS = 4'd1;
    tick();
    idle_inputs();
    chk("go_clears_timeout", 32'({TIMEOUT, BUSY}), 32'b01);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;

    // Pulse coincident with watchdog expiry wins
    GO = 1'b1; N_STEPS = 4'd2;
    tick();
    idle_inputs();
    tick();
    for (int k = 0; k < 15; k++) tick();
    TMR_PULSE = 1'b1;
    tick();
    TMR_PULSE = 1'b0;
    chk("coincide", 32'({STEP_TICK, TIMEOUT, BUSY, STEP}), 32'({1'b1, 1'b0, 1'b1, 4'd1}));
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;

    // Abort coincident with the second pulse of a 4-step run
    GO = 1'b1; N_STEPS = 4'd4;
    tick();
    idle_inputs();
    tick();
    TMR_PULSE = 1'b1;
    tick();
    TMR_PULSE = 1'b0;
    chk("ab4_first_tick", 32'({STEP_TICK, STEP}), 32'({1'b1, 4'd1}));
    tick();
    tick();
    TMR_PULSE = 1'b1; ABORT = 1'b1;
    tick();
    idle_inputs();
    chk("ab4_abort", 32'({STEP_TICK, DONE, BUSY, STEP}), 32'({3'b000, 4'd1}));

    // Asynchronous reset during WAIT of step 2
    GO = 1'b1; N_STEPS = 4'd3;
    tick();
    idle_inputs();
    tick();
    TMR_PULSE = 1'b1;
    tick();
    TMR_PULSE = 1'b0;
    tick();
    tick();
    chk("rst_pre_wait", 32'({BUSY, STEP}), 32'({1'b1, 4'd1}));
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
    tick();
    chk("rst_no_done", 32'(DONE), 32'd0);
    tick();
    RST_N = 1'b1;
    GO = 1'b1; N_STEPS = 4'd1;
    tick();
    idle_inputs();
    chk("rst_rego_arm", 32'({BUSY, STEP}), 32'({1'b1, 4'd0}));
    tick();
    chk("rst_rego_start", 32'(START_TMR), 32'd1);
    TMR_PULSE = 1'b1;
    tick();
    TMR_PULSE = 1'b0;
    chk("rst_rego_done", 32'({DONE, STEP_TICK, BUSY, STEP}), 32'({3'b110, 4'd1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
